// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : display_pkg
// Description : Shared constants and types for the seven-segment scan block.
//               Segment patterns are active-low, so an all-ones byte is a dark
//               digit.
// Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

    // All segments and the decimal point off.
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Bit positions inside one 8-bit segment pattern.
    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Phase inside one digit slot: GUARD keeps every digit dark so the
    // previous digit's charge cannot bleed into the next (ghosting).
    typedef enum logic [0:0] {
        GUARD = 1'b0,
        DRIVE = 1'b1
    } slot_phase_e;

endpackage
`default_nettype wire

// File: rtl/scan_timebase.sv
`default_nettype none
// ============================================================================
// Module      : scan_timebase
// Description : Refresh timebase for the digit scan. A cycle counter runs
//               0..CLK_DIV-1 per slot and a slot index rotates over the
//               digits. Both freeze while en_i is low.
// Ports       : clk, rst_n  - clock, asynchronous active-low reset
//               en_i        - advance the timebase
//               sel_o       - current slot index
//               wrap_o      - last cycle of the last slot (qualified by en_i)
//               phase_o     - GUARD for the first BLANK_CYCLES of a slot
// Revision    : 1.0 - initial release
// ============================================================================
module scan_timebase
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 2,
    parameter int SEL_W        = $clog2(NUM_DIGITS),
    parameter int CNT_W        = $clog2(CLK_DIV)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [SEL_W-1:0] sel_o,
    output logic             wrap_o,
    output slot_phase_e      phase_o
);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [SEL_W-1:0] C_SEL_LAST = SEL_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] C_BLANK    = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] r_cnt;
    logic [SEL_W-1:0] r_sel;
    logic             w_slot_end;

    assign w_slot_end = (r_cnt == C_CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_sel <= '0;
        end else if (en_i) begin
            if (w_slot_end) begin
                r_cnt <= '0;
                // Explicit wrap: NUM_DIGITS need not be a power of two.
                r_sel <= (r_sel == C_SEL_LAST) ? '0 : r_sel + SEL_W'(1);
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign sel_o   = r_sel;
    // A frozen timebase never wraps, so frame and buffer swap stall with it.
    assign wrap_o  = en_i && w_slot_end && (r_sel == C_SEL_LAST);
    assign phase_o = (r_cnt < C_BLANK) ? GUARD : DRIVE;

endmodule
`default_nettype wire

// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_ctrl
// Description : Multiplexed seven-segment scan controller with per-digit
//               blanking, guard cycles between digits and a double-buffered
//               frame so a displayed frame never mixes old and new data.
// Ports       : clk, rst_n     - clock, asynchronous active-low reset
//               en_i           - scan enable (low: freeze and blank)
//               seg_data_i     - 8 bits per digit, digit k at [8k+7:8k]
//               load_i         - adopt seg_data_i as the next frame
//               digit_en_i     - per-digit show (1) / blank (0)
//               an_o           - active-low digit enables, at most one low
//               seg_o          - active-low segments, bit 7 = dp
//               sel_o          - current slot index
//               frame_o        - pulse after each frame wrap
//               load_ack_o     - pulse when new data reaches the shadow
// Revision    : 1.0 - initial release
// ============================================================================
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SEL_W        = $clog2(NUM_DIGITS),
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en_i,
    input  logic [NUM_DIGITS*8-1:0] seg_data_i,
    input  logic                    load_i,
    input  logic [NUM_DIGITS-1:0]   digit_en_i,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic [7:0]              seg_o,
    output logic [SEL_W-1:0]        sel_o,
    output logic                    frame_o,
    output logic                    load_ack_o
);

    logic [SEL_W-1:0]        w_sel;
    logic                    w_wrap;
    slot_phase_e             w_phase;

    logic [NUM_DIGITS*8-1:0] r_staging;
    logic [NUM_DIGITS*8-1:0] r_shadow;
    logic                    r_pending;

    logic [7:0]              w_shadow_digit [NUM_DIGITS];
    logic                    w_digit_on;
    logic [NUM_DIGITS-1:0]   w_an_next;
    logic [7:0]              w_seg_next;

    scan_timebase #(
        .NUM_DIGITS   (NUM_DIGITS),
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES),
        .SEL_W        (SEL_W)
    ) u_timebase (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (en_i),
        .sel_o   (w_sel),
        .wrap_o  (w_wrap),
        .phase_o (w_phase)
    );

    generate
        for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit_unpack
            assign w_shadow_digit[k] = r_shadow[8*k +: 8];
        end
    endgenerate

    // A digit lights only in the DRIVE phase of its own, enabled slot.
    assign w_digit_on = en_i && (w_phase == DRIVE) && digit_en_i[w_sel];

    always_comb begin
        w_an_next  = '1;
        w_seg_next = SEG_BLANK;
        if (w_digit_on) begin
            w_an_next[w_sel] = 1'b0;
            w_seg_next       = w_shadow_digit[w_sel];
        end
    end

    // Double buffer: staging takes every load, the shadow only moves on a
    // frame wrap. A load in the wrap cycle itself bypasses staging so it is
    // not deferred by a whole frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_staging  <= '1;
            r_shadow   <= '1;
            r_pending  <= 1'b0;
            load_ack_o <= 1'b0;
        end else begin
            if (load_i) begin
                r_staging <= seg_data_i;
            end
            if (w_wrap) begin
                if (load_i) begin
                    r_shadow <= seg_data_i;
                end else if (r_pending) begin
                    r_shadow <= r_staging;
                end
                r_pending <= 1'b0;
            end else if (load_i) begin
                r_pending <= 1'b1;
            end
            load_ack_o <= w_wrap && (load_i || r_pending);
        end
    end

    // Registered pin drivers; they trail the timebase state by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_o    <= '1;
            seg_o   <= SEG_BLANK;
            sel_o   <= '0;
            frame_o <= 1'b0;
        end else begin
            an_o    <= w_an_next;
            seg_o   <= w_seg_next;
            sel_o   <= w_sel;
            frame_o <= w_wrap;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_scan_ctrl
// Description : Self-checking bench for display_scan_ctrl with NUM_DIGITS=4,
//               CLK_DIV=8, BLANK_CYCLES=2. Frame position j = 8*slot + cnt
//               names the timebase state that a registered output reflects.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scan_ctrl;

    localparam int NUM_DIGITS   = 4;
    localparam int CLK_DIV      = 8;
    localparam int BLANK_CYCLES = 2;
    localparam int SEL_W        = 2;

    localparam logic [31:0] DATA_BLANK = 32'hFFFF_FFFF;
    localparam logic [31:0] DATA_A     = 32'hC0F9_A4B0;
    localparam logic [31:0] DATA_JUNK  = 32'h1234_5678;
    localparam logic [31:0] DATA_NEW   = 32'h8280_F892;
    localparam logic [31:0] DATA_ZERO  = 32'h0000_0000;

    logic                    clk;
    logic                    rst_n;
    logic                    en_i;
    logic [NUM_DIGITS*8-1:0] seg_data_i;
    logic                    load_i;
    logic [NUM_DIGITS-1:0]   digit_en_i;
    logic [NUM_DIGITS-1:0]   an_o;
    logic [7:0]              seg_o;
    logic [SEL_W-1:0]        sel_o;
    logic                    frame_o;
    logic                    load_ack_o;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [3:0] an;
        logic [7:0] seg;
        logic [1:0] sel;
        logic       frame;
        logic       ack;
    } vec_t;

    vec_t       tbl [32];
    logic [3:0] an_drv  [4];
    logic [7:0] seg_exp [4];

    display_scan_ctrl #(
        .NUM_DIGITS   (NUM_DIGITS),
        .SEL_W        (SEL_W),
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (en_i),
        .seg_data_i (seg_data_i),
        .load_i     (load_i),
        .digit_en_i (digit_en_i),
        .an_o       (an_o),
        .seg_o      (seg_o),
        .sel_o      (sel_o),
        .frame_o    (frame_o),
        .load_ack_o (load_ack_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic chk_blank(input string tag, input logic [1:0] sel_exp);
        chk({tag, "_an"},    32'(an_o),       32'hF);
        chk({tag, "_seg"},   32'(seg_o),      32'hFF);
        chk({tag, "_sel"},   32'(sel_o),      32'(sel_exp));
        chk({tag, "_frame"}, 32'(frame_o),    32'h0);
        chk({tag, "_ack"},   32'(load_ack_o), 32'h0);
    endtask

    // Step through frame positions j0..j1 and compare against the displayed
    // frame data, the digit mask and whether an ack belongs on position 31.
    task automatic scan_check(input int j0, input int j1, input logic [31:0] data,
                              input logic [3:0] mask, input logic ack_last);
        for (int j = j0; j <= j1; j++) begin
            int         s = j / 8;
            int         c = j % 8;
            logic       on;
            logic [3:0] an_e;
            logic [7:0] seg_e;
            step();
            on    = (c >= BLANK_CYCLES) && mask[s];
            an_e  = on ? ~(4'b0001 << s) : 4'hF;
            seg_e = on ? data[s*8 +: 8] : 8'hFF;
            chk($sformatf("an@%0d", j),    32'(an_o),       32'(an_e));
            chk($sformatf("seg@%0d", j),   32'(seg_o),      32'(seg_e));
            chk($sformatf("sel@%0d", j),   32'(sel_o),      32'(s));
            chk($sformatf("frame@%0d", j), 32'(frame_o),    32'(j == 31));
            chk($sformatf("ack@%0d", j),   32'(load_ack_o), 32'((j == 31) && ack_last));
            chk($sformatf("onehot@%0d", j), 32'($countones(~an_o) <= 1), 32'h1);
        end
    endtask

    initial begin
        // Hand-computed slot values for data C0F9A4B0.
        an_drv[0]  = 4'b1110; an_drv[1]  = 4'b1101; an_drv[2]  = 4'b1011; an_drv[3]  = 4'b0111;
        seg_exp[0] = 8'hB0;   seg_exp[1] = 8'hA4;   seg_exp[2] = 8'hF9;   seg_exp[3] = 8'hC0;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 8; c++) begin
                tbl[s*8+c].an    = (c < 2) ? 4'hF  : an_drv[s];
                tbl[s*8+c].seg   = (c < 2) ? 8'hFF : seg_exp[s];
                tbl[s*8+c].sel   = 2'(s);
                tbl[s*8+c].frame = (s == 3) && (c == 7);
                tbl[s*8+c].ack   = 1'b0;
            end
        end

        rst_n      = 1'b0;
        en_i       = 1'b1;
        load_i     = 1'b0;
        seg_data_i = '0;
        digit_en_i = 4'hF;

        // 1. Reset values, then two blank frames of free-running scan.
        step();
        chk_blank("rst0", 2'd0);
        step();
        chk_blank("rst1", 2'd0);
        rst_n = 1'b1;
        scan_check(0, 31, DATA_BLANK, 4'hF, 1'b0);
        scan_check(0, 31, DATA_BLANK, 4'hF, 1'b0);

        // 2. Load a frame, let it swap in, then compare one frame by table.
        load_i = 1'b1; seg_data_i = DATA_A;
        scan_check(0, 0, DATA_BLANK, 4'hF, 1'b0);
        load_i = 1'b0;
        scan_check(1, 31, DATA_BLANK, 4'hF, 1'b1);
        for (int i = 0; i < 32; i++) begin
            step();
            chk($sformatf("tbl_an@%0d", i),    32'(an_o),       32'(tbl[i].an));
            chk($sformatf("tbl_seg@%0d", i),   32'(seg_o),      32'(tbl[i].seg));
            chk($sformatf("tbl_sel@%0d", i),   32'(sel_o),      32'(tbl[i].sel));
            chk($sformatf("tbl_frame@%0d", i), 32'(frame_o),    32'(tbl[i].frame));
            chk($sformatf("tbl_ack@%0d", i),   32'(load_ack_o), 32'(tbl[i].ack));
        end

        // 3. Two loads mid-frame: old data holds to the wrap, last load wins,
        //    single ack.
        scan_check(0, 11, DATA_A, 4'hF, 1'b0);
        load_i = 1'b1; seg_data_i = DATA_JUNK;
        scan_check(12, 12, DATA_A, 4'hF, 1'b0);
        load_i = 1'b0;
        scan_check(13, 19, DATA_A, 4'hF, 1'b0);
        load_i = 1'b1; seg_data_i = DATA_NEW;
        scan_check(20, 20, DATA_A, 4'hF, 1'b0);
        load_i = 1'b0;
        scan_check(21, 31, DATA_A, 4'hF, 1'b1);
        scan_check(0, 31, DATA_NEW, 4'hF, 1'b0);

        // 4. Load in the wrap cycle itself.
        scan_check(0, 30, DATA_NEW, 4'hF, 1'b0);
        load_i = 1'b1; seg_data_i = DATA_ZERO;
        scan_check(31, 31, DATA_NEW, 4'hF, 1'b1);
        load_i = 1'b0;
        scan_check(0, 31, DATA_ZERO, 4'hF, 1'b0);

        // 5. Digit 2 blanked, then freeze mid-DRIVE of slot 1 with a load
        //    arriving while frozen.
        digit_en_i = 4'b1011;
        scan_check(0, 31, DATA_ZERO, 4'b1011, 1'b0);
        scan_check(0, 12, DATA_ZERO, 4'b1011, 1'b0);
        en_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                load_i = 1'b1; seg_data_i = DATA_A;
            end
            step();
            load_i = 1'b0;
            chk_blank($sformatf("frz%0d", i), 2'd1);
        end
        en_i = 1'b1;
        scan_check(13, 31, DATA_ZERO, 4'b1011, 1'b1);
        scan_check(0, 31, DATA_A, 4'b1011, 1'b0);
        digit_en_i = 4'hF;

        // 6. Asynchronous reset mid-frame with a load pending.
        scan_check(0, 9, DATA_A, 4'hF, 1'b0);
        load_i = 1'b1; seg_data_i = DATA_ZERO;
        scan_check(10, 10, DATA_A, 4'hF, 1'b0);
        load_i = 1'b0;
        scan_check(11, 15, DATA_A, 4'hF, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_blank("arst_now", 2'd0);
        step();
        chk_blank("arst_h0", 2'd0);
        step();
        chk_blank("arst_h1", 2'd0);
        rst_n = 1'b1;
        scan_check(0, 31, DATA_BLANK, 4'hF, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
